x_multdiv_unit: RTL and testbench

- Execute-stage companion consuming the D/X latch outputs (instruction, operand A, operand B).
- Detects R-type mul/div and runs an iterative 32-cycle signed multiply or divide.
- Drives `stall` to freeze PC, F/D and D/X while busy.
- Delivers a one-cycle result/exception pulse that the X/M latch captures in place of the ALU result.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/multdiv_datapath.sv | 122 ++++++++++++
 rtl/x_multdiv_unit.sv | 123 ++++++++++++
 tb/tb_x_multdiv_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU definitions used by decode, the bypass unit and the
//               execute-stage multiply/divide companion.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Instruction field codes
    localparam logic [4:0] OPC_RTYPE = 5'b00000;
    localparam logic [4:0] ALU_MUL   = 5'b00110;
    localparam logic [4:0] ALU_DIV   = 5'b00111;

    // Multiply/divide sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_t;

    // Operation selected at launch
    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } md_op_t;

    // An R-type instruction whose ALU op field selects MUL or DIV
    function automatic logic is_md_instr(input logic [31:0] ir);
        return (ir[31:27] == OPC_RTYPE) &&
               ((ir[6:2] == ALU_MUL) || (ir[6:2] == ALU_DIV));
    endfunction

endpackage
`default_nettype wire

// File: rtl/multdiv_datapath.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_datapath
// Description : Shared iterative datapath for signed radix-2 Booth multiply
//               and signed non-restoring divide on magnitudes. Exposes the
//               final result and exception as seen after the current step so
//               the controller can register them on the last-step edge.
// Revision    : 1.0 - initial release
// ============================================================================
module multdiv_datapath
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             i_load,
    input  logic             i_step,
    input  md_op_t           i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result_nxt,
    output logic             o_exc_nxt
);

    // r_hi carries two guard bits: it is the Booth accumulator (so that
    // subtracting the most negative multiplicand cannot wrap) and the signed
    // partial remainder of the divider (range +/- 2*divisor).
    logic [WIDTH+1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;      // multiplier / quotient
    logic               r_qm1;     // Booth q(-1)
    logic [WIDTH-1:0]   r_m;       // multiplicand / divisor magnitude
    md_op_t             r_op;
    logic               r_neg;     // quotient sign

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH+1:0]   w_m_ext;
    logic [WIDTH+1:0]   w_sum;
    logic [WIDTH+1:0]   w_shift;
    logic [WIDTH+1:0]   w_rem;
    logic [WIDTH+1:0]   w_hi_nxt;
    logic [WIDTH-1:0]   w_lo_nxt;
    logic               w_qm1_nxt;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;

    assign w_a_neg = i_a[WIDTH-1];
    assign w_b_neg = i_b[WIDTH-1];
    assign w_a_mag = w_a_neg ? (~i_a + 1'b1) : i_a;
    assign w_b_mag = w_b_neg ? (~i_b + 1'b1) : i_b;

    // One Booth or non-restoring iteration, plus the resulting final outputs
    always_comb begin
        w_m_ext      = {{2{r_m[WIDTH-1]}}, r_m};
        w_sum        = r_hi;
        w_shift      = {r_hi[WIDTH:0], r_lo[WIDTH-1]};
        w_rem        = '0;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        w_qm1_nxt    = r_qm1;
        w_prod       = '0;
        w_quot       = '0;
        o_result_nxt = '0;
        o_exc_nxt    = 1'b0;
        if (r_op == OP_MUL) begin
            case ({r_lo[0], r_qm1})
                2'b01:   w_sum = r_hi + w_m_ext;
                2'b10:   w_sum = r_hi - w_m_ext;
                default: w_sum = r_hi;
            endcase
            {w_hi_nxt, w_lo_nxt, w_qm1_nxt} = {w_sum[WIDTH+1], w_sum, r_lo};
            w_prod       = {w_hi_nxt[WIDTH-1:0], w_lo_nxt};
            o_result_nxt = w_lo_nxt;
            // Product fits in WIDTH bits only if its top WIDTH+1 bits agree
            o_exc_nxt    = ~((&w_prod[2*WIDTH-1:WIDTH-1]) |
                             ~(|w_prod[2*WIDTH-1:WIDTH-1]));
        end else begin
            // Add back when the partial remainder is negative, else subtract
            w_rem        = r_hi[WIDTH+1] ? (w_shift + {2'b00, r_m})
                                         : (w_shift - {2'b00, r_m});
            w_hi_nxt     = w_rem;
            w_lo_nxt     = {r_lo[WIDTH-2:0], ~w_rem[WIDTH+1]};
            w_quot       = w_lo_nxt;
            o_result_nxt = r_neg ? (~w_quot + 1'b1) : w_quot;
            // Only -2^(W-1) / -1 yields a positive quotient of 2^(W-1)
            o_exc_nxt    = ~r_neg & w_quot[WIDTH-1];
        end
    end

    // Operand capture on launch, one iteration per step
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_qm1 <= 1'b0;
            r_m   <= '0;
            r_op  <= OP_MUL;
            r_neg <= 1'b0;
        end else if (i_load) begin
            r_hi  <= '0;
            r_qm1 <= 1'b0;
            r_op  <= i_op;
            r_neg <= w_a_neg ^ w_b_neg;
            if (i_op == OP_MUL) begin
                r_lo <= i_a;
                r_m  <= i_b;
            end else begin
                r_lo <= w_a_mag;
                r_m  <= w_b_mag;
            end
        end else if (i_step) begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_qm1 <= w_qm1_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/x_multdiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : x_multdiv_unit
// Description : Execute-stage multiply/divide companion. Detects R-type
//               MUL/DIV in the D/X latch, stalls the front of the pipe while
//               iterating, and pulses result_rdy with the result/exception.
// Revision    : 1.0 - initial release
// ============================================================================
module x_multdiv_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [31:0]      ir_x,
    input  logic [WIDTH-1:0] dataA_x,
    input  logic [WIDTH-1:0] dataB_x,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             result_rdy,
    output logic [WIDTH-1:0] result,
    output logic             exception
);

    localparam int               CNT_W  = $clog2(ITER) + 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(ITER - 1);

    md_state_t        r_state;
    logic [CNT_W-1:0] r_count;

    logic             w_is_md;
    logic             w_is_div;
    logic             w_start;
    logic             w_div_zero;
    logic             w_load;
    logic             w_step;
    md_op_t           w_op;
    logic [WIDTH-1:0] w_result_nxt;
    logic             w_exc_nxt;

    assign w_is_md    = is_md_instr(ir_x);
    assign w_is_div   = (ir_x[6:2] == ALU_DIV);
    assign w_op       = w_is_div ? OP_DIV : OP_MUL;
    assign w_start    = (r_state == IDLE) & w_is_md & ~flush;
    assign w_div_zero = w_is_div & (dataB_x == '0);
    assign w_load     = w_start & ~w_div_zero;
    assign w_step     = (r_state == BUSY) & ~flush;

    // Upstream latches hold while an operation is launching or iterating
    assign stall = w_start | (r_state == BUSY);

    multdiv_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk          (clk),
        .clr          (clr),
        .i_load       (w_load),
        .i_step       (w_step),
        .i_op         (w_op),
        .i_a          (dataA_x),
        .i_b          (dataB_x),
        .o_result_nxt (w_result_nxt),
        .o_exc_nxt    (w_exc_nxt)
    );

    // Sequencer with registered busy/result outputs
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state    <= IDLE;
            r_count    <= '0;
            busy       <= 1'b0;
            result_rdy <= 1'b0;
            result     <= '0;
            exception  <= 1'b0;
        end else begin
            result_rdy <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        if (w_div_zero) begin
                            // Divide by zero finishes without iterating
                            r_state    <= DONE;
                            result_rdy <= 1'b1;
                            result     <= '0;
                            exception  <= 1'b1;
                        end else begin
                            r_state <= BUSY;
                            r_count <= '0;
                            busy    <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (flush) begin
                        // Squashed: drop the operation, keep the old result
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end else if (r_count == C_LAST) begin
                        r_state    <= DONE;
                        busy       <= 1'b0;
                        result_rdy <= 1'b1;
                        result     <= w_result_nxt;
                        exception  <= w_exc_nxt;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_x_multdiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_x_multdiv_unit
// Description : Scoreboard bench for x_multdiv_unit. Expected results are
//               computed by a behavioural model when an op is presented and
//               compared when result_rdy pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_x_multdiv_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] ir_x;
    logic [31:0] dataA_x;
    logic [31:0] dataB_x;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        result_rdy;
    logic [31:0] result;
    logic        exception;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] res;
        logic        exc;
    } exp_t;

    exp_t sb_q[$];

    x_multdiv_unit #(
        .WIDTH (32),
        .ITER  (32)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .ir_x       (ir_x),
        .dataA_x    (dataA_x),
        .dataB_x    (dataB_x),
        .flush      (flush),
        .stall      (stall),
        .busy       (busy),
        .result_rdy (result_rdy),
        .result     (result),
        .exception  (exception)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic exp_t model(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b);
        exp_t               e;
        logic signed [63:0] p;
        logic signed [31:0] q;
        if (ir[6:2] == ALU_MUL) begin
            p     = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            e.res = p[31:0];
            e.exc = (p[63:31] != {33{p[31]}});
        end else if (b == 32'h0) begin
            e.res = 32'h0;
            e.exc = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.res = 32'h8000_0000;
            e.exc = 1'b1;
        end else begin
            q     = $signed(a) / $signed(b);
            e.res = q;
            e.exc = 1'b0;
        end
        return e;
    endfunction

    // R-type MUL/DIV with random don't-care fields
    function automatic logic [31:0] mk_ir(input logic [4:0] aluop);
        logic [19:0] mid;
        logic [1:0]  lo;
        mid = 20'($urandom);
        lo  = 2'($urandom);
        return {OPC_RTYPE, mid, aluop, lo};
    endfunction

    // Scoreboard consumer
    always @(negedge clk) begin
        exp_t e;
        if (result_rdy === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_rdy", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("result", result, e.res);
                chk("exception", exception, e.exc);
            end
        end
    end

    // Present an op at a negedge, wait for its result pulse, check latency
    task automatic run_op(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input bit chk_pipe);
        int n;
        bit seen;
        ir_x    = ir;
        dataA_x = a;
        dataB_x = b;
        sb_q.push_back(model(ir, a, b));
        if (chk_pipe) begin
            #1;
            chk("stall_c0", stall, 1'b1);
            chk("busy_c0", busy, 1'b0);
        end
        n    = 0;
        seen = 0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (result_rdy === 1'b1) begin
                seen = 1;
            end else if (chk_pipe) begin
                chk("stall_busy", {stall, busy}, 2'b11);
            end
        end
        chk("latency", n, exp_lat);
        if (chk_pipe) chk("stall_done", stall, 1'b0);
        ir_x = 32'h0;
    endtask

    initial begin
        logic [31:0] held;
        logic [31:0] ra;
        logic [31:0] rb;
        clr     = 1'b1;
        ir_x    = 32'h0;
        dataA_x = 32'h0;
        dataB_x = 32'h0;
        flush   = 1'b0;
        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_rdy", result_rdy, 1'b0);
        chk("rst_result", result, 32'h0);
        chk("rst_exc", exception, 1'b0);
        chk("rst_stall", stall, 1'b0);
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);

        // Basic multiply with full pipeline-control checks
        run_op(mk_ir(ALU_MUL), 32'd7, 32'hFFFF_FFFD, 33, 1);
        @(negedge clk);

        // Divide followed back-to-back by an overflowing multiply
        run_op(mk_ir(ALU_DIV), 32'd100, 32'hFFFF_FFF9, 33, 1);
        run_op(mk_ir(ALU_MUL), 32'h0001_0000, 32'h0001_0000, 34, 0);
        @(negedge clk);

        // Divide by zero finishes in one cycle
        run_op(mk_ir(ALU_DIV), 32'd5, 32'd0, 1, 1);
        @(negedge clk);

        // Most negative / -1
        run_op(mk_ir(ALU_DIV), 32'h8000_0000, 32'hFFFF_FFFF, 33, 1);
        @(negedge clk);

        // Flush mid-iteration: no result, previous result held
        held    = result;
        ir_x    = mk_ir(ALU_MUL);
        dataA_x = 32'd1234;
        dataB_x = 32'd5678;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        ir_x  = 32'h0;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", busy, 1'b0);
        chk("flush_stall", stall, 1'b0);
        chk("flush_held", result, held);
        repeat (40) @(negedge clk);
        chk("flush_held_late", result, held);

        // Asynchronous clear mid-iteration
        ir_x    = mk_ir(ALU_MUL);
        dataA_x = 32'd12345;
        dataB_x = 32'hFFFF_FD5A;
        repeat (15) @(negedge clk);
        ir_x = 32'h0;
        #2 clr = 1'b1;
        #1;
        chk("clr_busy", busy, 1'b0);
        chk("clr_rdy", result_rdy, 1'b0);
        chk("clr_result", result, 32'h0);
        chk("clr_exc", exception, 1'b0);
        chk("clr_stall", stall, 1'b0);
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        run_op(mk_ir(ALU_MUL), 32'd12345, 32'hFFFF_FD5A, 33, 1);
        @(negedge clk);

        // Non-MUL/DIV instructions must not start anything
        ir_x = {OPC_RTYPE, 20'h12345, 5'b00000, 2'b00};
        #1 chk("nonmd_alu_stall", stall, 1'b0);
        ir_x = {5'b00101, 20'h0, ALU_MUL, 2'b00};
        #1 chk("nonmd_opc_stall", stall, 1'b0);
        repeat (3) @(negedge clk);
        chk("nonmd_busy", busy, 1'b0);
        ir_x = 32'h0;
        @(negedge clk);

        // Random signed operands
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = (i % 4 == 3) ? 32'($urandom_range(1, 50)) : $urandom;
            if (i[1]) ra = ra >>> 12;
            run_op(mk_ir((i % 2 == 0) ? ALU_MUL : ALU_DIV), ra, rb, 33, 0);
            @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
